imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Boot-time program loader upstream of the single-cycle core. Takes a byte stream (UART RX or
//  debug bridge), assembles little-endian 32-bit words and writes them into instruction memory
//  through its write port. Holds the core in reset until the image is fully written.
// PARAMETERS
//  ADDR_WIDTH  10  instruction memory word-address width; depth = 2**ADDR_WIDTH words (<=16)
//  DATA_WIDTH  32  instruction word width; fixed at 32 (4 bytes per word)
// PORTS
//  clk          in   1           system clock
//  reset        in   1           asynchronous, active-high reset
//  start        in   1           single-cycle pulse; re-arms the loader from DONE or ERROR
//  rx_data      in   8           stream byte
//  rx_valid     in   1           rx_data valid
//  rx_ready     out  1           loader accepts a byte this cycle
//  imem_we      out  1           instruction memory write enable
//  imem_addr    out  ADDR_WIDTH  instruction memory word address
//  imem_wdata   out  32          instruction memory write data
//  core_reset_n out  1           drives the core's active-low reset_n; 0 while loading or in error
//  load_busy    out  1           loader is in a load sequence
//  load_done    out  1           image loaded; core released
//  load_error   out  1           load aborted; core held in reset
// BEHAVIOUR
//  - Byte accepted iff rx_valid && rx_ready. rx_ready is a registered function of state only and
//    never depends on rx_valid.
//  - Frame format: CNT_LO, CNT_HI (16-bit word count N, little-endian), then 4*N payload bytes,
//    byte 0 = instr[7:0] ... byte 3 = instr[31:24].
//  - States: HDR_LO -> HDR_HI -> DATA <-> WRITE -> DONE; any state may go to ERROR.
//    - rx_ready = 1 in HDR_LO, HDR_HI, DATA (and CHK); 0 in WRITE, DONE, ERROR.
//  - Reset: state = HDR_LO; word_idx = 0; byte_idx = 0; imem_we = 0; imem_addr = 0; imem_wdata = 0;
//    core_reset_n = 0; load_busy = 1; load_done = 0; load_error = 0.
//  - HDR_HI exit:
//    - N == 0: go to DONE.
//    - N > 2**ADDR_WIDTH: go to ERROR. No memory write occurs.
//    - Otherwise: go to DATA.
//  - DATA: byte_idx counts 0..3. The 4th accepted byte moves to WRITE.
//  - WRITE lasts exactly 1 cycle, with imem_we = 1, imem_addr = word_idx, imem_wdata = assembled word.
//    - Latency: imem_we is high the cycle after the 4th byte is accepted.
//    - Afterwards, word_idx++. If word_idx was N-1, go to DONE; else go to DATA.
//  - imem_we is high only in WRITE. imem_addr never wraps, because N is bounded by depth.
//  - DONE: core_reset_n = 1, load_done = 1, load_busy = 0.
//  - ERROR: core_reset_n = 0, load_error = 1, load_busy = 0.
//  - start in DONE or ERROR:
//    - Next state is HDR_LO, with counters cleared.
//    - core_reset_n drops to 0 in the same edge that leaves DONE.
//    - load_done and load_error clear.
//  - start while load_busy = 1 is ignored. rx_valid in DONE or ERROR is ignored (not consumed).
//  - Reset mid-load: immediate return to the reset values. Partially written memory is not
//    cleared; a new frame overwrites it.
// CONFIGURATION
//  Macro IMEM_LOADER_CHECKSUM_EN:
//  - Defined:
//    - State CHK follows the last WRITE, or HDR_HI when N == 0.
//    - CHK expects one byte equal to the XOR of all frame bytes before it, header included.
//    - Match -> DONE. Mismatch -> ERROR.
//    - The running XOR resets on reset and on start.
//  - Undefined:
//    - No CHK state and no XOR register. The frame ends after the last payload byte.
// STRUCTURE
//  - imem_loader_pkg:
//    - typedef enum loader_state_t {HDR_LO, HDR_HI, DATA, WRITE, CHK, DONE, ERROR}.
//    - localparam BYTES_PER_WORD = 4.
//    - localparam CNT_WIDTH = 16.
//  - Sub-module word_assembler:
//    - Takes byte, byte_valid and clear.
//    - Outputs word[31:0] and word_valid.
//    - Little-endian shift-in with a 2-bit byte counter.
// TESTING
//  1. Reset, then frame 01 00 13 05 A0 00.
//     Expect exactly one imem_we pulse with addr 0 and wdata 0x00A00513, then load_done = 1 and
//     core_reset_n = 1.
//  2. Frame 03 00 + 12 bytes, with rx_valid toggling randomly.
//     Expect writes to addr 0, 1, 2 in order, each 1 cycle after its 4th byte.
//     rx_ready must be 0 during each WRITE.
//  3. Header 01 04 (N = 1025, with ADDR_WIDTH = 10).
//     Expect ERROR: load_error = 1, no imem_we ever, core_reset_n = 0.
//  4. Header 00 00.
//     Expect DONE 1 cycle after CNT_HI, no writes.
//     With IMEM_LOADER_CHECKSUM_EN, checksum byte 00 is required before DONE.
//  5. Load done, then start pulse, then a second frame.
//     Expect core_reset_n = 0 again, new words written, load_done set again.
//     start pulsed mid-load is ignored.
//  6. reset asserted after 2 payload bytes, then a full frame.
//     Expect outputs at reset values immediately and a correct load from addr 0.
//     With IMEM_LOADER_CHECKSUM_EN:
//     - Frame 01 00 13 05 A0 00 + checksum 0xB7 -> DONE.
//     - Same frame + checksum 0xB6 -> ERROR.

Source files
------------

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader_pkg
//  Purpose  : Shared types and constants for the instruction-memory loader:
//             loader FSM state encoding, bytes per instruction word and
//             width of the frame word-count field.
//  Revision : 1.0  initial release
// ============================================================================
package imem_loader_pkg;

    // Explicit 3-bit encoding; CHK exists only when the checksum build
    // option is enabled, but keeps its code so encodings never shift.
    typedef enum logic [2:0] {
        HDR_LO = 3'd0,
        HDR_HI = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        CHK    = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_WIDTH      = 16;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : word_assembler
//  Purpose  : Little-endian byte-to-word packer. Each accepted byte is
//             shifted in from the top, so the first byte of a group ends up
//             in word[7:0] and the last in word[31:24].
//  Ports    : clk, reset (async, active-high)
//             clear       - drop any partial word and restart at byte 0
//             byte_in     - incoming byte
//             byte_valid  - byte_in is consumed this cycle
//             word        - assembled word (holds until the next byte)
//             word_valid  - combinational: this byte completes a word; the
//                           complete word is on 'word' from the next cycle
//  Revision : 1.0  initial release
// ============================================================================
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic [7:0]                    byte_in,
    input  logic                          byte_valid,
    output logic [8*BYTES_PER_WORD-1:0]   word,
    output logic                          word_valid
);

    localparam int                c_idx_w = $clog2(BYTES_PER_WORD);
    localparam logic [c_idx_w-1:0] c_last = c_idx_w'(BYTES_PER_WORD - 1);

    logic [8*BYTES_PER_WORD-1:0] r_word_q, w_word_d;
    logic [c_idx_w-1:0]          r_idx_q,  w_idx_d;

    always_comb begin
        w_word_d = r_word_q;
        w_idx_d  = r_idx_q;
        if (clear) begin
            w_idx_d = '0;
        end else if (byte_valid) begin
            w_word_d = {byte_in, r_word_q[8*BYTES_PER_WORD-1:8]};
            w_idx_d  = r_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word_q <= '0;
            r_idx_q  <= '0;
        end else begin
            r_word_q <= w_word_d;
            r_idx_q  <= w_idx_d;
        end
    end

    assign word       = r_word_q;
    assign word_valid = byte_valid && !clear && (r_idx_q == c_last);

endmodule : word_assembler
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Boot-time program loader. Receives a byte frame
//             (CNT_LO, CNT_HI, 4*N payload bytes), packs little-endian
//             32-bit words and writes them to instruction memory, holding
//             the core in reset until the image is complete.
//  Build option:
//             IMEM_LOADER_CHECKSUM_EN - frame carries a trailing XOR byte of
//             all preceding frame bytes; a mismatch aborts to ERROR.
//  Ports    : clk, reset (async, active-high), start (re-arm pulse)
//             rx_data/rx_valid/rx_ready      - byte stream handshake
//             imem_we/imem_addr/imem_wdata   - instruction memory write port
//             core_reset_n                   - core reset, released in DONE
//             load_busy/load_done/load_error - loader status
//  Revision : 1.0  initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  core_reset_n,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_error
);

    // Largest legal word count is the memory depth itself; one extra bit so
    // a depth of 2**CNT_WIDTH would still be representable.
    localparam logic [CNT_WIDTH:0] c_depth = (CNT_WIDTH + 1)'(1) << ADDR_WIDTH;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t c_frame_end = CHK;
`else
    localparam loader_state_t c_frame_end = DONE;
`endif

    loader_state_t          r_state_q,    w_state_d;
    logic [7:0]             r_cnt_lo_q,   w_cnt_lo_d;
    logic [CNT_WIDTH-1:0]   r_word_cnt_q, w_word_cnt_d;
    logic [CNT_WIDTH-1:0]   r_word_idx_q, w_word_idx_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]             r_xor_q,      w_xor_d;
`endif

    logic                   w_accept;
    logic                   w_rearm;
    logic [CNT_WIDTH-1:0]   w_hdr_n;
    logic                   w_word_valid;
    logic [31:0]            w_word;

    assign w_accept = rx_valid && rx_ready;
    assign w_rearm  = start && ((r_state_q == DONE) || (r_state_q == ERROR));
    assign w_hdr_n  = {rx_data, r_cnt_lo_q};

    word_assembler u_word_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (w_rearm),
        .byte_in    (rx_data),
        .byte_valid (w_accept && (r_state_q == DATA)),
        .word       (w_word),
        .word_valid (w_word_valid)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_lo_d   = r_cnt_lo_q;
        w_word_cnt_d = r_word_cnt_q;
        w_word_idx_d = r_word_idx_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        w_xor_d      = r_xor_q;
        // Every frame byte ahead of the checksum byte is folded in.
        if (w_accept && (r_state_q != CHK)) begin
            w_xor_d = r_xor_q ^ rx_data;
        end
`endif
        case (r_state_q)
            HDR_LO: begin
                if (w_accept) begin
                    w_cnt_lo_d = rx_data;
                    w_state_d  = HDR_HI;
                end
            end
            HDR_HI: begin
                if (w_accept) begin
                    w_word_cnt_d = w_hdr_n;
                    if (w_hdr_n == '0) begin
                        w_state_d = c_frame_end;
                    end else if ({1'b0, w_hdr_n} > c_depth) begin
                        w_state_d = ERROR;
                    end else begin
                        w_state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (w_word_valid) begin
                    w_state_d = WRITE;
                end
            end
            WRITE: begin
                w_word_idx_d = r_word_idx_q + 1'b1;
                if (r_word_idx_q == (r_word_cnt_q - 1'b1)) begin
                    w_state_d = c_frame_end;
                end else begin
                    w_state_d = DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (w_accept) begin
                    w_state_d = (rx_data == r_xor_q) ? DONE : ERROR;
                end
            end
`endif
            DONE, ERROR: begin
                if (start) begin
                    w_state_d    = HDR_LO;
                    w_cnt_lo_d   = '0;
                    w_word_cnt_d = '0;
                    w_word_idx_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_xor_d      = '0;
`endif
                end
            end
            default: begin
                // Unreachable encodings park the loader safely.
                w_state_d = ERROR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q    <= HDR_LO;
            r_cnt_lo_q   <= '0;
            r_word_cnt_q <= '0;
            r_word_idx_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor_q      <= '0;
`endif
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_lo_q   <= w_cnt_lo_d;
            r_word_cnt_q <= w_word_cnt_d;
            r_word_idx_q <= w_word_idx_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor_q      <= w_xor_d;
`endif
        end
    end

    // All outputs are decoded from registered state only.
    assign rx_ready     = (r_state_q == HDR_LO) || (r_state_q == HDR_HI) ||
                          (r_state_q == DATA)   || (r_state_q == CHK);
    assign imem_we      = (r_state_q == WRITE);
    assign imem_addr    = r_word_idx_q[ADDR_WIDTH-1:0];
    assign imem_wdata   = w_word;
    assign core_reset_n = (r_state_q == DONE);
    assign load_done    = (r_state_q == DONE);
    assign load_error   = (r_state_q == ERROR);
    assign load_busy    = (r_state_q != DONE) && (r_state_q != ERROR);

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Self-checking bench for imem_loader. Frames are built from
//             word lists; the expected write sequence and write timing are
//             derived from the frame layout (header, 4 bytes per word,
//             optional XOR trailer).
//  Revision : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_reset_n;
    logic          load_busy;
    logic          load_done;
    logic          load_error;

    imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset_n (core_reset_n),
        .load_busy    (load_busy),
        .load_done    (load_done),
        .load_error   (load_error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected write list and frame tracking shared with the monitor.
    logic [15:0] exp_addr [0:2047];
    logic [31:0] exp_data [0:2047];
    int exp_wr     = 0;
    int exp_rd     = 0;
    int mon_pos    = 0;
    int frame_base = 0;
    int mon_n      = 0;

    // Monitor: a write must appear exactly one cycle after the byte that
    // completes a payload word, carry the next expected addr/data, and
    // never coincide with rx_ready.
    initial begin : p_monitor
        bit pend;
        int rel;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend || imem_we) chk("we_timing", 32'(imem_we), 32'(pend));
            if (imem_we) begin
                if (exp_rd < exp_wr) begin
                    chk("imem_addr", 32'(imem_addr), 32'(exp_addr[exp_rd]));
                    chk("imem_wdata", imem_wdata, exp_data[exp_rd]);
                end else begin
                    chk("extra_write", 32'(exp_rd), 32'(exp_wr));
                end
                chk("rx_ready_in_write", 32'(rx_ready), 32'd0);
                exp_rd++;
            end
            pend = 1'b0;
            if (rx_valid && rx_ready) begin
                rel = mon_pos - frame_base;
                if (rel >= 2 && rel < 2 + 4 * mon_n && ((rel - 2) % 4) == 3) pend = 1'b1;
                mon_pos++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit got;
        int guard;
        got   = 1'b0;
        guard = 0;
        rx_data = b;
        while (!got) begin
            rx_valid = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (rx_valid && rx_ready) got = 1'b1;
            @(posedge clk);
            #1;
            guard++;
            if (!got && guard > 200) begin
                chk("rx_accept_timeout", 32'(rx_ready), 32'd1);
                got = 1'b1;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_end();
        int g;
        g = 0;
        while (!(load_done || load_error) && g < 300) begin
            @(posedge clk);
            #1;
            g++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_we"},      32'(imem_we), 32'd0);
        chk({tag, "_addr"},    32'(imem_addr), 32'd0);
        chk({tag, "_wdata"},   imem_wdata, 32'd0);
        chk({tag, "_corern"},  32'(core_reset_n), 32'd0);
        chk({tag, "_busy"},    32'(load_busy), 32'd1);
        chk({tag, "_done"},    32'(load_done), 32'd0);
        chk({tag, "_error"},   32'(load_error), 32'd0);
        chk({tag, "_rdy"},     32'(rx_ready), 32'd1);
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_done"},   32'(load_done), 32'd1);
        chk({tag, "_corern"}, 32'(core_reset_n), 32'd1);
        chk({tag, "_busy"},   32'(load_busy), 32'd0);
        chk({tag, "_error"},  32'(load_error), 32'd0);
        chk({tag, "_rdy"},    32'(rx_ready), 32'd0);
    endtask

    task automatic check_error(input string tag);
        chk({tag, "_error"},  32'(load_error), 32'd1);
        chk({tag, "_corern"}, 32'(core_reset_n), 32'd0);
        chk({tag, "_busy"},   32'(load_busy), 32'd0);
        chk({tag, "_done"},   32'(load_done), 32'd0);
        chk({tag, "_rdy"},    32'(rx_ready), 32'd0);
    endtask

    task automatic rearm(input string tag);
        pulse_start();
        chk({tag, "_corern"}, 32'(core_reset_n), 32'd0);
        chk({tag, "_done"},   32'(load_done), 32'd0);
        chk({tag, "_error"},  32'(load_error), 32'd0);
        chk({tag, "_busy"},   32'(load_busy), 32'd1);
    endtask

    // Reference: frame = count (LE) + words (LE bytes) [+ XOR of all prior bytes].
    task automatic build_frame(input logic [31:0] words[$], output logic [7:0] fr[$]);
        int n;
        logic [31:0] w;
        n = words.size();
        fr = {};
        fr.push_back(8'(n));
        fr.push_back(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int k = 0; k < 4; k++) fr.push_back(8'(w >> (8 * k)));
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            foreach (fr[i]) x = x ^ fr[i];
            fr.push_back(x);
        end
`endif
    endtask

    task automatic load_frame(input logic [31:0] words[$], input bit pulse_mid, input string tag);
        logic [7:0] fr[$];
        build_frame(words, fr);
        for (int i = 0; i < words.size(); i++) begin
            exp_addr[exp_wr] = 16'(i);
            exp_data[exp_wr] = words[i];
            exp_wr++;
        end
        frame_base = mon_pos;
        mon_n      = words.size();
        for (int i = 0; i < fr.size(); i++) begin
            send_byte(fr[i]);
            if (pulse_mid && i == 3) begin
                pulse_start();
                chk({tag, "_midstart_busy"}, 32'(load_busy), 32'd1);
            end
        end
        wait_end();
        check_done(tag);
        chk({tag, "_nwrites"}, 32'(exp_rd), 32'(exp_wr));
    endtask

    task automatic send_header(input int n);
        frame_base = mon_pos;
        mon_n      = n;
        send_byte(8'(n));
        send_byte(8'(n >> 8));
    endtask

    initial begin : p_main
        logic [31:0] words[$];
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vals("post_reset");

        // Directed single word.
        words = {32'h00A00513};
        load_frame(words, 1'b0, "single");
        rearm("rearm1");

        // Random frames; the second one also gets a start pulse mid-load.
        for (int k = 0; k < 4; k++) begin
            int n;
            n = (k == 0) ? 3 : $urandom_range(1, 6);
            words = {};
            for (int i = 0; i < n; i++) words.push_back($urandom());
            load_frame(words, k == 1, "rand");
            rearm("rearm_rand");
        end

        // Largest legal image fills the whole memory.
        words = {};
        for (int i = 0; i < (1 << AW); i++) words.push_back($urandom());
        load_frame(words, 1'b0, "full_depth");
        rearm("rearm_full");

        // One word too many: immediate ERROR, no writes.
        send_header((1 << AW) + 1);
        check_error("oversize");
        repeat (4) @(posedge clk);
        #1;
        chk("oversize_nwrites", 32'(exp_rd), 32'(exp_wr));
        rearm("rearm_err");

        // Empty image.
        send_header(0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("empty_wait_chk", 32'(load_done), 32'd0);
        chk("empty_chk_rdy", 32'(rx_ready), 32'd1);
        send_byte(8'h00);
`endif
        check_done("empty");
        chk("empty_nwrites", 32'(exp_rd), 32'(exp_wr));
        rearm("rearm_empty");

        // Reset after two payload bytes, then a clean reload from address 0.
        send_header(2);
        send_byte(8'h5A);
        send_byte(8'hC3);
        reset = 1'b1;
        #1;
        check_reset_vals("midreset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        words = {$urandom(), $urandom()};
        load_frame(words, 1'b0, "after_reset");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Known checksum of the directed frame is 0xB7; 0xB6 must be rejected.
        rearm("rearm_good");
        words = {32'h00A00513};
        load_frame(words, 1'b0, "chk_good");
        rearm("rearm_bad");
        exp_addr[exp_wr] = 16'd0;
        exp_data[exp_wr] = 32'h00A00513;
        exp_wr++;
        send_header(1);
        send_byte(8'h13);
        send_byte(8'h05);
        send_byte(8'hA0);
        send_byte(8'h00);
        wait_end();
        chk("chk_wait_rdy", 32'(rx_ready), 32'd1);
        send_byte(8'hB6);
        check_error("chk_bad");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_imem_loader
`default_nettype wire
